// File: rtl/shift_sequencer.sv
// shift_sequencer: iterates a single-step shifter amt times per request over valid/ready handshakes
// Optional out_carry (last bit shifted out) enabled by defining SHIFT_CARRY_EN.
module shift_sequencer #(
    parameter int W     = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [1:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    output logic [W-1:0]     sh_data,
    output logic [1:0]       sh_code,
    input  logic [W-1:0]     sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
`ifdef SHIFT_CARRY_EN
    output logic             out_carry,
`endif
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state, state_nxt;
    logic [W-1:0]     work;
    logic [AMT_W-1:0] cnt;
    logic [1:0]       op;
    logic             accept;
`ifdef SHIFT_CARRY_EN
    logic             carry;
    assign out_carry = carry;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= '0;
            cnt   <= '0;
            op    <= 2'b00;
`ifdef SHIFT_CARRY_EN
            carry <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                work  <= in_data;
                op    <= in_op;
                cnt   <= in_amt;
`ifdef SHIFT_CARRY_EN
                carry <= 1'b0;
`endif
            end else if (state == SHIFT) begin
                work  <= sh_result;
                cnt   <= cnt - 1'b1;
`ifdef SHIFT_CARRY_EN
                carry <= (op == 2'b01) ? work[W-1] : work[0];
`endif
            end
        end
    end
    always_comb begin
        state_nxt = state;
        in_ready  = rst_n && (state == IDLE);
        accept    = in_valid && in_ready;
        out_valid = rst_n && (state == DONE);
        busy      = rst_n && (state != IDLE);
        sh_data   = work;
        sh_code   = (state == SHIFT) ? op : 2'b00;
        out_data  = work;
        case (state)
            IDLE:    state_nxt = !accept ? IDLE : ((in_amt == '0 || in_op == 2'b00) ? DONE : SHIFT);
            SHIFT:   state_nxt = (cnt == AMT_W'(1)) ? DONE : SHIFT;
            DONE:    state_nxt = out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed vector table plus handshake/back-pressure/reset sequences
// Drives a behavioural single-step shifter on sh_data/sh_code; carry checks under SHIFT_CARRY_EN.
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [1:0]  in_op = '0;
    logic [3:0]  in_amt = '0;
    logic [15:0] sh_data;
    logic [1:0]  sh_code;
    logic [15:0] sh_result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        busy;
    logic        out_carry;
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // Reference single-step shifter (00 pass, 01 LSL, 10 LSR, 11 ASR)
    assign sh_result = (sh_code == 2'b01) ? {sh_data[14:0], 1'b0} :
                       (sh_code == 2'b10) ? {1'b0, sh_data[15:1]} :
                       (sh_code == 2'b11) ? {sh_data[15], sh_data[15:1]} : sh_data;

    shift_sequencer #(.W(16), .AMT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_op(in_op), .in_amt(in_amt),
        .sh_data(sh_data), .sh_code(sh_code), .sh_result(sh_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef SHIFT_CARRY_EN
        .out_carry(out_carry),
`endif
        .busy(busy)
    );
`ifndef SHIFT_CARRY_EN
    assign out_carry = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        logic [1:0]  op;
        logic [3:0]  amt;
        logic [15:0] exp_data;
        logic        exp_carry;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int idx);
        int n = 0;
        int codes = 0;
        int eff;
        eff = (v.op == 2'b00) ? 0 : int'(v.amt);
        @(negedge clk);
        check($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = v.data; in_op = v.op; in_amt = v.amt;
        @(negedge clk);
        in_valid = 1'b0; in_data = 16'hDEAD; in_op = 2'b11; in_amt = 4'hF;
        while (!out_valid && n < 40) begin
            if (sh_code != 2'b00) codes += (sh_code == v.op) ? 1 : 100;
            n++;
            @(negedge clk);
        end
        if (n >= 40) begin
            n_vec++; n_err++;
            $display("FAIL v%0d timeout: out_valid not seen after %0d cycles", idx, n);
        end
        check($sformatf("v%0d out_data", idx), 32'(out_data), 32'(v.exp_data));
        check($sformatf("v%0d steps", idx), 32'(n), 32'(eff));
        check($sformatf("v%0d sh_code cycles", idx), 32'(codes), 32'(eff));
        check($sformatf("v%0d busy", idx), 32'(busy), 32'd1);
`ifdef SHIFT_CARRY_EN
        check($sformatf("v%0d out_carry", idx), 32'(out_carry), 32'(v.exp_carry));
`endif
        @(negedge clk);
        check($sformatf("v%0d out_valid cleared", idx), 32'(out_valid), 32'd0);
    endtask

    initial begin
        vec_t tbl[11];
        logic [15:0] held;
        int seen;
        tbl = '{
            '{16'h0001, 2'b01, 4'd4,  16'h0010, 1'b0},
            '{16'h8000, 2'b11, 4'd3,  16'hF000, 1'b0},
            '{16'h8000, 2'b10, 4'd3,  16'h1000, 1'b0},
            '{16'hABCD, 2'b01, 4'd0,  16'hABCD, 1'b0},
            '{16'h1234, 2'b00, 4'd9,  16'h1234, 1'b0},
            '{16'h8001, 2'b01, 4'd1,  16'h0002, 1'b1},
            '{16'h0003, 2'b10, 4'd2,  16'h0000, 1'b1},
            '{16'h8001, 2'b11, 4'd1,  16'hC000, 1'b1},
            '{16'h0001, 2'b01, 4'd15, 16'h8000, 1'b0},
            '{16'hFFFF, 2'b10, 4'd15, 16'h0001, 1'b1},
            '{16'h7FFF, 2'b11, 4'd15, 16'h0000, 1'b1}
        };
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("release in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 11; i++) run(tbl[i], i);

        // Back-pressure: result held 5 cycles while a second request waits
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h00F0; in_op = 2'b10; in_amt = 4'd2;
        @(negedge clk);
        in_data = 16'h0003; in_op = 2'b01; in_amt = 4'd1;
        seen = 0;
        while (!out_valid && seen < 20) begin seen++; @(negedge clk); end
        check("bp out_data", 32'(out_data), 32'h003C);
        held = out_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d out_data", k), 32'(out_data), 32'(held));
            check($sformatf("bp%0d in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp turnaround out_valid", 32'(out_valid), 32'd0);
        check("bp turnaround busy", 32'(busy), 32'd0);
        check("bp turnaround in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp second accepted", 32'(busy), 32'd1);
        seen = 0;
        while (!out_valid && seen < 20) begin seen++; @(negedge clk); end
        check("bp second out_data", 32'(out_data), 32'h0006);
        @(negedge clk);

        // Reset at step 2 of an 8-step shift
        in_valid = 1'b1; in_data = 16'h0001; in_op = 2'b01; in_amt = 4'd8;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid sh_code", 32'(sh_code), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid reset in_ready", 32'(in_ready), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid reset idle", 32'(in_ready), 32'd1);
        check("mid reset out_data", 32'(out_data), 32'd0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid || busy) seen++;
            @(negedge clk);
        end
        check("mid reset no out_valid", 32'(seen), 32'd0);
        run(tbl[0], 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
